// File: rtl/mem_stage.sv
// mem_stage: LDW/STW via req/ack data port, branch redirect, writeback forwarding.
// Optional MEM_TIMEOUT_EN: abort an unacknowledged access after TIMEOUT edges.
package mem_pkg;
  localparam int REG_WIDTH    = 16;
  localparam int OPCODE_WIDTH = 8;
  localparam int PC_WIDTH     = 16;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = 8'h00;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = 8'h01;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 8'h02;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND   = 8'h03;
  localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = 8'h04;
  localparam logic [OPCODE_WIDTH-1:0] OP_MOV   = 8'h05;
  localparam logic [OPCODE_WIDTH-1:0] OP_MOVI  = 8'h06;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDW   = 8'h10;
  localparam logic [OPCODE_WIDTH-1:0] OP_STW   = 8'h11;
  localparam logic [OPCODE_WIDTH-1:0] OP_BR    = 8'h20;
  localparam logic [OPCODE_WIDTH-1:0] OP_BRN   = 8'h21;
  localparam logic [OPCODE_WIDTH-1:0] OP_BRZ   = 8'h22;
  localparam logic [OPCODE_WIDTH-1:0] OP_BRP   = 8'h23;
  localparam logic [OPCODE_WIDTH-1:0] OP_BRNZ  = 8'h24;
  localparam logic [OPCODE_WIDTH-1:0] OP_BRNP  = 8'h25;
  localparam logic [OPCODE_WIDTH-1:0] OP_BRZP  = 8'h26;
  localparam logic [OPCODE_WIDTH-1:0] OP_BRNZP = 8'h27;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP   = 8'h28;
  localparam logic [OPCODE_WIDTH-1:0] OP_JSR   = 8'h29;
  localparam logic [OPCODE_WIDTH-1:0] OP_JSRR  = 8'h2A;
endpackage

module mem_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 15
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET,
  input  logic                    I_LOCK,
  input  logic [REG_WIDTH-1:0]    I_ALUOut,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [3:0]              I_DestRegIdx,
  input  logic [REG_WIDTH-1:0]    I_DestValue,
  input  logic                    I_FetchStall,
  input  logic                    I_DepStall,
  input  logic                    I_MemAck,
  input  logic [REG_WIDTH-1:0]    I_MemRData,
  output logic                    O_MemReq,
  output logic                    O_MemWE,
  output logic [ADDR_W-1:0]       O_MemAddr,
  output logic [REG_WIDTH-1:0]    O_MemWData,
  output logic                    O_MemStall,
  output logic                    O_LOCK,
  output logic [OPCODE_WIDTH-1:0] O_Opcode,
  output logic [3:0]              O_DestRegIdx,
  output logic [REG_WIDTH-1:0]    O_DestValue,
  output logic                    O_FetchStall,
  output logic                    O_DepStall,
  output logic [PC_WIDTH-1:0]     O_BranchPC,
  output logic                    O_BranchValid,
  output logic                    O_MemErr
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state, state_n;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic [3:0] idx_q;
  logic accept, is_mem, is_alu, is_jsr, is_br;
  logic done, tmo;

  assign accept = (state == S_IDLE) && I_LOCK
               && !I_FetchStall && !I_DepStall;
  assign is_mem = I_Opcode inside {OP_LDW, OP_STW};
  assign is_alu = I_Opcode inside {OP_ADD, OP_ADDI, OP_AND,
                                   OP_ANDI, OP_MOV, OP_MOVI};
  assign is_jsr = I_Opcode inside {OP_JSR, OP_JSRR};
  assign is_br  = I_Opcode inside {OP_BR, OP_BRN, OP_BRZ,
                                   OP_BRP, OP_BRNZ, OP_BRNP,
                                   OP_BRZP, OP_BRNZP, OP_JMP};
  assign done   = (state == S_WAIT) && I_MemAck;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;

  // ack on the expiry edge takes priority over the abort
  assign tmo = (state == S_WAIT) && !I_MemAck
            && (cnt == CW'(TIMEOUT - 1));

  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      cnt      <= '0;
      O_MemErr <= 1'b0;
    end else begin
      O_MemErr <= tmo;
      if (state == S_WAIT && !done && !tmo)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
    end
  end
`else
  assign tmo      = 1'b0;
  assign O_MemErr = 1'b0;
`endif

  always_comb begin
    state_n = state;
    if (accept && is_mem)
      state_n = S_WAIT;
    if (done || tmo)
      state_n = S_IDLE;
  end

  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) state <= S_IDLE;
    else         state <= state_n;
  end

  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      O_MemReq      <= 1'b0;
      O_MemWE       <= 1'b0;
      O_MemAddr     <= '0;
      O_MemWData    <= '0;
      O_MemStall    <= 1'b0;
      O_LOCK        <= 1'b0;
      O_Opcode      <= OP_NOP;
      O_DestRegIdx  <= '0;
      O_DestValue   <= '0;
      O_FetchStall  <= 1'b0;
      O_DepStall    <= 1'b0;
      O_BranchPC    <= '0;
      O_BranchValid <= 1'b0;
      op_q          <= OP_NOP;
      idx_q         <= '0;
    end else begin
      O_LOCK        <= I_LOCK;
      O_FetchStall  <= I_FetchStall;
      O_DepStall    <= I_DepStall;
      O_Opcode      <= OP_NOP;
      O_BranchValid <= 1'b0;
      if (accept) begin
        unique case (1'b1)
          is_mem: begin
            O_MemReq   <= 1'b1;
            O_MemStall <= 1'b1;
            O_MemWE    <= (I_Opcode == OP_STW);
            O_MemAddr  <= I_ALUOut[ADDR_W-1:0];
            O_MemWData <= I_DestValue;
            op_q       <= I_Opcode;
            idx_q      <= I_DestRegIdx;
          end
          is_alu, is_jsr: begin
            O_Opcode     <= I_Opcode;
            O_DestRegIdx <= I_DestRegIdx;
            O_DestValue  <= I_ALUOut;
            if (is_jsr) begin
              O_BranchPC    <= I_DestValue[PC_WIDTH-1:0];
              O_BranchValid <= 1'b1;
            end
          end
          is_br: begin
            O_Opcode      <= I_Opcode;
            O_BranchPC    <= I_DestValue[PC_WIDTH-1:0];
            O_BranchValid <= 1'b1;
          end
          default: ;
        endcase
      end
      if (done || tmo) begin
        O_MemReq     <= 1'b0;
        O_MemWE      <= 1'b0;
        O_MemStall   <= 1'b0;
        O_Opcode     <= op_q;
        O_DestRegIdx <= idx_q;
        if (op_q == OP_LDW)
          O_DestValue <= done ? I_MemRData : '0;
        else
          O_DestValue <= O_MemWData;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage (directed vectors).
// Define MEM_TIMEOUT_EN to also exercise the timeout abort.
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b1;
  logic        rst;
  logic        lock;
  logic [15:0] alu_out;
  logic [7:0]  opcode;
  logic [3:0]  dest_idx;
  logic [15:0] dest_val;
  logic        fetch_stall, dep_stall;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        mem_req, mem_we, mem_stall;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        o_lock;
  logic [7:0]  o_opcode;
  logic [3:0]  o_idx;
  logic [15:0] o_val;
  logic        o_fs, o_ds;
  logic [15:0] br_pc;
  logic        br_valid, mem_err;

  mem_stage #(.ADDR_W(10), .TIMEOUT(15)) dut (
    .I_CLOCK(clk), .I_RESET(rst), .I_LOCK(lock),
    .I_ALUOut(alu_out), .I_Opcode(opcode),
    .I_DestRegIdx(dest_idx), .I_DestValue(dest_val),
    .I_FetchStall(fetch_stall), .I_DepStall(dep_stall),
    .I_MemAck(mem_ack), .I_MemRData(mem_rdata),
    .O_MemReq(mem_req), .O_MemWE(mem_we),
    .O_MemAddr(mem_addr), .O_MemWData(mem_wdata),
    .O_MemStall(mem_stall), .O_LOCK(o_lock),
    .O_Opcode(o_opcode), .O_DestRegIdx(o_idx),
    .O_DestValue(o_val), .O_FetchStall(o_fs),
    .O_DepStall(o_ds), .O_BranchPC(br_pc),
    .O_BranchValid(br_valid), .O_MemErr(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic        wb;
    logic [3:0]  idx;
    logic [15:0] val;
    logic        bv;
    logic [15:0] bpc;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  bit mon_en = 0;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push(logic [7:0] op, logic wb,
                               logic [3:0] idx, logic [15:0] val,
                               logic bv, logic [15:0] bpc,
                               logic err);
    exp_t e;
    e.op = op; e.wb = wb; e.idx = idx; e.val = val;
    e.bv = bv; e.bpc = bpc; e.err = err;
    sb.push_back(e);
  endfunction

  // monitor: samples on the rising edge, away from the active edge
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (mon_en && (o_opcode !== OP_NOP || br_valid !== 1'b0
                     || mem_err !== 1'b0)) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {o_opcode, 7'd0, br_valid,
              7'd0, mem_err}, {OP_NOP, 16'd0});
        end else begin
          e = sb.pop_front();
          chk("wb_opcode", o_opcode, e.op);
          if (e.wb) begin
            chk("wb_idx", o_idx, e.idx);
            chk("wb_value", o_val, e.val);
          end
          chk("branch_valid", br_valid, e.bv);
          if (e.bv) chk("branch_pc", br_pc, e.bpc);
          chk("mem_err", mem_err, e.err);
        end
      end
    end
  end

  task automatic idle_inputs();
    lock = 0; opcode = OP_NOP; alu_out = 0; dest_idx = 0;
    dest_val = 0; fetch_stall = 0; dep_stall = 0;
  endtask

  task automatic issue(input logic [7:0] op, input logic [15:0] alu,
                       input logic [3:0] idx, input logic [15:0] dv);
    lock = 1; opcode = op; alu_out = alu;
    dest_idx = idx; dest_val = dv;
    @(negedge clk); #1;
    idle_inputs();
  endtask

  // delay = edges from accept to the edge that samples the ack
  task automatic mem_op(input logic [7:0] op, input logic [15:0] addr,
                        input logic [15:0] data, input logic [3:0] idx,
                        input int delay, input logic [15:0] rdata,
                        input bit noise);
    issue(op, addr, idx, data);
    for (int i = 0; i < delay; i++) begin
      chk("wait_req", mem_req, 1'b1);
      chk("wait_stall", mem_stall, 1'b1);
      chk("wait_addr", mem_addr, addr[9:0]);
      chk("wait_we", mem_we, op == OP_STW);
      if (op == OP_STW) chk("wait_wdata", mem_wdata, data);
      if (noise) begin
        lock = 1; opcode = OP_ADD; alu_out = 16'h7777;
      end
      if (i == delay - 1) begin
        mem_ack = 1; mem_rdata = rdata;
      end
      @(negedge clk); #1;
      idle_inputs();
    end
    mem_ack = 0; mem_rdata = 16'hDEAD;
    chk("done_req", mem_req, 1'b0);
    chk("done_stall", mem_stall, 1'b0);
    chk("done_we", mem_we, 1'b0);
  endtask

  initial begin
    idle_inputs();
    rst = 1; mem_ack = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_opcode", o_opcode, OP_NOP);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_stall", mem_stall, 1'b0);
    chk("rst_bv", br_valid, 1'b0);
    chk("rst_value", o_val, 16'h0);
    chk("rst_lock", o_lock, 1'b0);
    chk("rst_err", mem_err, 1'b0);
    rst = 0;
    mon_en = 1;

    push(OP_ADDI, 1, 4'd3, 16'h0012, 0, 0, 0);
    issue(OP_ADDI, 16'h0012, 4'd3, 16'h0);
    chk("addi_req", mem_req, 1'b0);
    chk("lock_copy", o_lock, 1'b1);

    push(OP_ADD, 1, 4'd7, 16'hA5A5, 0, 0, 0);
    push(OP_AND, 1, 4'd1, 16'h00F0, 0, 0, 0);
    push(OP_MOVI, 1, 4'd15, 16'hFFFF, 0, 0, 0);
    issue(OP_ADD, 16'hA5A5, 4'd7, 16'h1111);
    issue(OP_AND, 16'h00F0, 4'd1, 16'h2222);
    issue(OP_MOVI, 16'hFFFF, 4'd15, 16'h3333);

    push(OP_JSR, 1, 4'd7, 16'h0031, 1, 16'h0100, 0);
    issue(OP_JSR, 16'h0031, 4'd7, 16'h0100);

    push(OP_BRZ, 0, 4'd0, 16'h0, 1, 16'h0020, 0);
    issue(OP_BRZ, 16'h0, 4'd0, 16'h0020);
    chk("brz_valid", br_valid, 1'b1);
    @(negedge clk); #1;
    chk("brz_pulse_end", br_valid, 1'b0);

    fetch_stall = 1;
    lock = 1; opcode = OP_ADD; alu_out = 16'h5555;
    @(negedge clk); #1;
    chk("fetch_stall_copy", o_fs, 1'b1);
    chk("bubble_opcode", o_opcode, OP_NOP);
    idle_inputs();
    dep_stall = 1; lock = 1; opcode = OP_ADD;
    @(negedge clk); #1;
    chk("dep_stall_copy", o_ds, 1'b1);
    idle_inputs();

    push(OP_LDW, 1, 4'd2, 16'hBEEF, 0, 0, 0);
    mem_op(OP_LDW, 16'h0040, 16'h0000, 4'd2, 3, 16'hBEEF, 1);

    push(OP_STW, 1, 4'd4, 16'h1234, 0, 0, 0);
    mem_op(OP_STW, 16'h0005, 16'h1234, 4'd4, 1, 16'h0, 0);

    push(OP_ADDI, 1, 4'd9, 16'h0abc, 0, 0, 0);
    issue(OP_ADDI, 16'h0abc, 4'd9, 16'h0);

    push(OP_LDW, 1, 4'd5, 16'hCAFE, 0, 0, 0);
    mem_op(OP_LDW, 16'h03FF, 16'h0000, 4'd5, 1, 16'hCAFE, 0);
    push(OP_STW, 1, 4'd6, 16'h0F0F, 0, 0, 0);
    mem_op(OP_STW, 16'h0200, 16'h0F0F, 4'd6, 2, 16'h0, 0);

    mem_ack = 1; mem_rdata = 16'h9999;
    repeat (2) @(negedge clk);
    #1;
    mem_ack = 0;
    chk("idle_ack_req", mem_req, 1'b0);

    issue(OP_LDW, 16'h0077, 4'd8, 16'h0);
    @(negedge clk); #1;
    chk("pre_rst_req", mem_req, 1'b1);
    rst = 1;
    @(negedge clk); #1;
    rst = 0;
    chk("midwait_rst_req", mem_req, 1'b0);
    chk("midwait_rst_stall", mem_stall, 1'b0);
    chk("midwait_rst_opcode", o_opcode, OP_NOP);
    push(OP_MOV, 1, 4'd10, 16'h4321, 0, 0, 0);
    issue(OP_MOV, 16'h4321, 4'd10, 16'h0);

`ifdef MEM_TIMEOUT_EN
    push(OP_LDW, 1, 4'd11, 16'h0000, 0, 0, 1);
    issue(OP_LDW, 16'h0123, 4'd11, 16'h0);
    for (int i = 0; i < 15; i++) begin
      chk("tmo_req", mem_req, 1'b1);
      @(negedge clk); #1;
    end
    chk("tmo_stall", mem_stall, 1'b0);
    chk("tmo_err", mem_err, 1'b1);
    @(negedge clk); #1;
    chk("tmo_err_pulse", mem_err, 1'b0);
    push(OP_LDW, 1, 4'd12, 16'h5A5A, 0, 0, 0);
    mem_op(OP_LDW, 16'h0124, 16'h0, 4'd12, 15, 16'h5A5A, 0);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the 5-stage pipeline, consuming the Execute stage's outputs (ALU result, opcode, destination index, destination/PC value, stall flags). It performs LDW/STW through a request/acknowledge data-memory port and stalls the upstream stages while an access is outstanding. It redirects fetch for control-flow opcodes and forwards results to Writeback.

## Interface
- ADDR_W, 10: data-memory word address width; `I_ALUOut[ADDR_W-1:0]` is the address.
- TIMEOUT, 15: cycles to wait for `I_MemAck` before abort (only with MEM_TIMEOUT_EN).
- One clock; reset is synchronous and active-high.
- I_CLOCK  in  1  clock; all state updates on the falling edge.
- I_RESET  in  1  synchronous, active-high reset.
- I_LOCK  in  1  pipeline enable from Execute.
- I_ALUOut  in  REG_WIDTH  ALU result or effective address.
- I_Opcode  in  OPCODE_WIDTH  opcode.
- I_DestRegIdx  in  4  destination register.
- I_DestValue  in  REG_WIDTH  store data, or target PC for control flow.
- I_FetchStall, I_DepStall  in  1 each  upstream bubble flags.
- I_MemAck  in  1  data memory acknowledge.
- I_MemRData  in  REG_WIDTH  load data, valid with I_MemAck.
- O_MemReq, O_MemWE  out  1 each  request / write enable.
- O_MemAddr  out  ADDR_W  address.
- O_MemWData  out  REG_WIDTH  store data.
- O_MemStall  out  1  upstream stages must hold their outputs.
- O_LOCK  out  1  registered copy of I_LOCK.
- O_Opcode  out  OPCODE_WIDTH  opcode to Writeback (`OP_NOP` for a bubble).
- O_DestRegIdx  out  4  destination register.
- O_DestValue  out  REG_WIDTH  writeback value.
- O_FetchStall, O_DepStall  out  1 each  registered copies of the inputs.
- O_BranchPC  out  PC_WIDTH  redirect target.
- O_BranchValid  out  1  one-cycle redirect pulse.
- O_MemErr  out  1  one-cycle timeout pulse.

## Operation
- Accept condition: state IDLE, I_LOCK=1, I_FetchStall=0, I_DepStall=0. Otherwise a bubble is emitted: O_Opcode=`OP_NOP`.
- ADD/ADDI/AND/ANDI/MOV/MOVI: O_DestValue←I_ALUOut, O_DestRegIdx←I_DestRegIdx, O_Opcode←I_Opcode.
- JSR/JSRR: as ALU ops (link value in I_ALUOut). Also O_BranchPC←I_DestValue[PC_WIDTH-1:0] and O_BranchValid=1.
- BR*/JMP: O_BranchPC←I_DestValue, O_BranchValid=1, O_Opcode←I_Opcode.
- LDW/STW: latch address, data, opcode and index, then move IDLE→WAIT. In WAIT:
  - O_MemReq=1; O_MemWE=1 for STW.
  - O_MemAddr and O_MemWData are held stable.
  - O_MemStall=1.
  - Downstream sees `OP_NOP`.
- WAIT with I_MemAck=1 → IDLE:
  - O_MemReq and O_MemStall drop.
  - LDW: O_DestValue←I_MemRData.
  - STW: O_DestValue←stored data, write-back suppressed by opcode.
  - O_Opcode←latched opcode.
- Inputs are ignored in WAIT; upstream holds them while O_MemStall=1.
- I_MemAck in IDLE is ignored.
- Reset, including mid-WAIT:
  - State goes to IDLE.
  - All outputs go to 0, except O_Opcode=`OP_NOP`.
  - The pending access is dropped without an error pulse.

## Timing
- Non-memory ops: result on the first falling edge after presentation (1-cycle latency).
- O_BranchValid is high for exactly one cycle.
- Memory op accepted at edge k: O_MemReq/O_MemStall high from edge k.
- I_MemAck is sampled at edges ≥ k+1. The result appears at the same edge as the sampled ack, so minimum memory latency is 2 edges.
- The next instruction can be accepted at the edge after the ack edge.
- Back-to-back memory ops: there is no idle edge between the ack edge and the next accept edge, beyond that following-edge rule.
- O_LOCK, O_FetchStall, O_DepStall: always registered copies of their inputs, independent of state.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - If TIMEOUT edges pass without I_MemAck, the stage returns to IDLE and O_MemErr pulses for 1 cycle.
  - LDW writes back 0; O_MemStall drops.
  - An ack arriving on the timeout edge wins: normal completion, no error.
- MEM_TIMEOUT_EN undefined: WAIT holds indefinitely; O_MemErr is tied to 0.

## Test plan
- ADDI result 0x0012, DestRegIdx 3 → next edge O_DestValue=0x0012, O_DestRegIdx=3, O_MemReq=0.
- LDW addr 0x0040, ack after 3 cycles with data 0xBEEF:
  - O_MemReq/O_MemStall high for 3 cycles, O_MemAddr=0x040 stable.
  - Then O_DestValue=0xBEEF and O_Opcode=LDW.
- STW addr 0x0005, data 0x1234, ack at the first sample → O_MemWE=1, O_MemWData=0x1234 for one cycle, no stall afterward.
- BRZ with I_DestValue=0x0020 → O_BranchPC=0x0020, O_BranchValid high exactly 1 cycle.
- I_RESET asserted in WAIT → next edge O_MemReq=0, O_MemStall=0, O_Opcode=`OP_NOP`, state IDLE.
- With MEM_TIMEOUT_EN and TIMEOUT=15, LDW never acked → after 15 edges O_MemErr pulses once, O_DestValue=0, O_MemStall=0.
